vx_commit_arbiter: RTL and testbench

// - Commit stage directly upstream of the issue stage's writeback port: merges result beats from N execution units into one writeback stream per issue slot.
// - That stream feeds the scoreboard (releases pending rd) and the GPR file (register write).
// - Round-robin fair; multi-beat results stay contiguous via eop lock; counts committed instructions.

---
 rtl/vx_commit_arbiter.sv | 169 ++++++++++++++++
 tb/tb_vx_commit_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/vx_commit_arbiter.sv
// Round-robin commit merge of N execution-unit beat streams into one writeback stream, with eop lock.
// One cycle from accept to wb_valid; always ready for one beat per cycle (ready is one-hot grant, zero in reset).
module vx_commit_arbiter #(
  parameter int NUM_SRCS      = 4,
  parameter int NUM_THREADS   = 4,
  parameter int XLEN          = 32,
  parameter int NW_BITS       = 2,
  parameter int NR_BITS       = 6,
  parameter int UUID_WIDTH    = 44,
  parameter int PERF_CTR_BITS = 44,
  localparam int DATAW = UUID_WIDTH + NW_BITS + NUM_THREADS + XLEN + 1 + NR_BITS
                         + NUM_THREADS * XLEN + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_SRCS-1:0]           commit_valid,
  input  logic [NUM_SRCS*DATAW-1:0]     commit_data,
  output logic [NUM_SRCS-1:0]           commit_ready,
  output logic                          wb_valid,
  output logic [UUID_WIDTH-1:0]         wb_uuid,
  output logic [NW_BITS-1:0]            wb_wid,
  output logic [NUM_THREADS-1:0]        wb_tmask,
  output logic [XLEN-1:0]               wb_PC,
  output logic [NR_BITS-1:0]            wb_rd,
  output logic [NUM_THREADS*XLEN-1:0]   wb_data,
  output logic                          wb_eop,
  output logic [PERF_CTR_BITS-1:0]      commit_count
);

  localparam int PTR_W    = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1;
  localparam int DATA_LSB = 1;
  localparam int RD_LSB   = DATA_LSB + NUM_THREADS * XLEN;
  localparam int WB_BIT   = RD_LSB + NR_BITS;
  localparam int PC_LSB   = WB_BIT + 1;
  localparam int TM_LSB   = PC_LSB + XLEN;
  localparam int WID_LSB  = TM_LSB + NUM_THREADS;
  localparam int UUID_LSB = WID_LSB + NW_BITS;

  logic [PTR_W-1:0]               rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]               lock_idx_q, lock_idx_d;
  logic                           lock_q, lock_d;
  logic [PERF_CTR_BITS-1:0]       count_q, count_d;

  logic                           wb_valid_q;
  logic [UUID_WIDTH-1:0]          wb_uuid_q;
  logic [NW_BITS-1:0]             wb_wid_q;
  logic [NUM_THREADS-1:0]         wb_tmask_q;
  logic [XLEN-1:0]                wb_pc_q;
  logic [NR_BITS-1:0]             wb_rd_q;
  logic [NUM_THREADS*XLEN-1:0]    wb_data_q;
  logic                           wb_eop_q;

  logic [NUM_SRCS-1:0]            eligible;
  logic [PTR_W-1:0]               winner;
  logic                           winner_vld;
  logic [DATAW-1:0]               beat;
  logic [PTR_W:0]                 scan_idx;
  logic [PTR_W:0]                 next_ptr;

  // While locked only the owner may win; a bubble from the owner blocks everyone else.
  always_comb begin
    eligible = commit_valid;
    if (lock_q) begin
      eligible             = '0;
      eligible[lock_idx_q] = commit_valid[lock_idx_q];
    end
  end

  // Scan from the farthest offset down so the offset closest to rr_ptr wins last.
  always_comb begin
    winner     = '0;
    winner_vld = 1'b0;
    scan_idx   = '0;
    for (int k = NUM_SRCS - 1; k >= 0; k--) begin
      scan_idx = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (scan_idx >= (PTR_W+1)'(NUM_SRCS)) begin
        scan_idx = scan_idx - (PTR_W+1)'(NUM_SRCS);
      end
      if (eligible[scan_idx[PTR_W-1:0]]) begin
        winner     = scan_idx[PTR_W-1:0];
        winner_vld = 1'b1;
      end
    end
  end

  // No grant during reset: the registers cannot capture the beat.
  always_comb begin
    commit_ready = '0;
    if (winner_vld && reset) begin
      commit_ready[winner] = 1'b1;
    end
  end

  always_comb begin
    beat = '0;
    for (int i = 0; i < NUM_SRCS; i++) begin
      if (winner == PTR_W'(i)) begin
        beat = commit_data[i*DATAW +: DATAW];
      end
    end
  end

  always_comb begin
    next_ptr = {1'b0, winner} + (PTR_W+1)'(1);
    if (next_ptr >= (PTR_W+1)'(NUM_SRCS)) begin
      next_ptr = next_ptr - (PTR_W+1)'(NUM_SRCS);
    end
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    count_d    = count_q;
    if (winner_vld) begin
      if (beat[0]) begin
        lock_d   = 1'b0;
        rr_ptr_d = next_ptr[PTR_W-1:0];
        count_d  = count_q + PERF_CTR_BITS'(1);
      end else begin
        lock_d     = 1'b1;
        lock_idx_d = winner;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      count_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_uuid_q  <= '0;
      wb_wid_q   <= '0;
      wb_tmask_q <= '0;
      wb_pc_q    <= '0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_eop_q   <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      count_q    <= count_d;
      wb_valid_q <= winner_vld & beat[WB_BIT];
      if (winner_vld) begin
        wb_uuid_q  <= beat[UUID_LSB +: UUID_WIDTH];
        wb_wid_q   <= beat[WID_LSB +: NW_BITS];
        wb_tmask_q <= beat[TM_LSB +: NUM_THREADS];
        wb_pc_q    <= beat[PC_LSB +: XLEN];
        wb_rd_q    <= beat[RD_LSB +: NR_BITS];
        wb_data_q  <= beat[DATA_LSB +: NUM_THREADS*XLEN];
        wb_eop_q   <= beat[0];
      end
    end
  end

  assign wb_valid     = wb_valid_q;
  assign wb_uuid      = wb_uuid_q;
  assign wb_wid       = wb_wid_q;
  assign wb_tmask     = wb_tmask_q;
  assign wb_PC        = wb_pc_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign wb_eop       = wb_eop_q;
  assign commit_count = count_q;

endmodule

// File: tb/tb_vx_commit_arbiter.sv
// Directed bench for vx_commit_arbiter: reset, fairness, eop lock, no-writeback, data path, counter wrap.
module tb_vx_commit_arbiter;

  localparam int DATAW = 44 + 2 + 4 + 32 + 1 + 6 + 128 + 1;

  logic             clk;
  logic             reset;
  logic [3:0]       commit_valid;
  logic [4*DATAW-1:0] commit_data;
  logic [3:0]       commit_ready;
  logic             wb_valid;
  logic [43:0]      wb_uuid;
  logic [1:0]       wb_wid;
  logic [3:0]       wb_tmask;
  logic [31:0]      wb_PC;
  logic [5:0]       wb_rd;
  logic [127:0]     wb_data;
  logic             wb_eop;
  logic [43:0]      commit_count;

  int n_chk  = 0;
  int n_pass = 0;

  vx_commit_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .commit_valid (commit_valid),
    .commit_data  (commit_data),
    .commit_ready (commit_ready),
    .wb_valid     (wb_valid),
    .wb_uuid      (wb_uuid),
    .wb_wid       (wb_wid),
    .wb_tmask     (wb_tmask),
    .wb_PC        (wb_PC),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .wb_eop       (wb_eop),
    .commit_count (commit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [DATAW-1:0] mk(input logic [43:0] uuid, input logic [1:0] wid,
                                          input logic [3:0] tm, input logic [31:0] pc,
                                          input logic wb, input logic [5:0] rd,
                                          input logic [127:0] data, input logic eop);
    return {uuid, wid, tm, pc, wb, rd, data, eop};
  endfunction

  function automatic logic [DATAW-1:0] simple(input int src, input int rd, input logic wb,
                                              input logic eop);
    return mk(44'(src), 2'd0, 4'hF, 32'h100 + 32'(src * 4), wb, 6'(rd), 128'(rd), eop);
  endfunction

  task automatic drive(input int i, input logic v, input logic [DATAW-1:0] b);
    commit_valid[i] = v;
    commit_data[i*DATAW +: DATAW] = b;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 4; i++) drive(i, 1'b0, '0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [127:0] lanes;

  initial begin
    reset        = 1'b0;
    commit_valid = '0;
    commit_data  = '0;
    tick();
    tick();
    chk("rst_wb_valid", 256'(wb_valid), 256'(0));
    chk("rst_wb_rd", 256'(wb_rd), 256'(0));
    chk("rst_wb_data", 256'(wb_data), 256'(0));
    chk("rst_count", 256'(commit_count), 256'(0));
    chk("rst_ready", 256'(commit_ready), 256'(0));

    // Fairness: all four sources stream single-beat results.
    reset = 1'b1;
    for (int i = 0; i < 4; i++) drive(i, 1'b1, simple(i, 10 + i, 1'b1, 1'b1));
    #1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("rr_ready_%0d", k), 256'(commit_ready), 256'(4'b0001 << (k % 4)));
      tick();
      chk($sformatf("rr_rd_%0d", k), 256'(wb_rd), 256'(10 + (k % 4)));
      chk($sformatf("rr_valid_%0d", k), 256'(wb_valid), 256'(1));
    end
    chk("rr_count", 256'(commit_count), 256'(8));
    idle_all();
    tick();
    chk("idle_valid", 256'(wb_valid), 256'(0));

    // No-writeback beat: accepted and counted, but no wb_valid.
    drive(0, 1'b1, simple(0, 5, 1'b0, 1'b1));
    #1;
    chk("nowb_ready", 256'(commit_ready), 256'(4'b0001));
    tick();
    idle_all();
    chk("nowb_valid", 256'(wb_valid), 256'(0));
    chk("nowb_count", 256'(commit_count), 256'(9));

    // Data path, src2 alone (rr_ptr is 1).
    lanes = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    drive(2, 1'b1, mk(44'h123, 2'd3, 4'b1010, 32'h8000_0040, 1'b1, 6'd17, lanes, 1'b1));
    #1;
    chk("dp_ready", 256'(commit_ready), 256'(4'b0100));
    tick();
    idle_all();
    chk("dp_valid", 256'(wb_valid), 256'(1));
    chk("dp_uuid", 256'(wb_uuid), 256'(44'h123));
    chk("dp_wid", 256'(wb_wid), 256'(3));
    chk("dp_tmask", 256'(wb_tmask), 256'(4'b1010));
    chk("dp_pc", 256'(wb_PC), 256'(32'h8000_0040));
    chk("dp_rd", 256'(wb_rd), 256'(17));
    chk("dp_data", 256'(wb_data), 256'(lanes));
    chk("dp_eop", 256'(wb_eop), 256'(1));
    chk("dp_count", 256'(commit_count), 256'(10));

    // Move rr_ptr to 1 with a lone src0 beat.
    drive(0, 1'b1, simple(0, 1, 1'b1, 1'b1));
    tick();
    chk("pre_lock_rd", 256'(wb_rd), 256'(1));

    // Lock: src1 three-beat packet with a bubble, src0/src3 contending.
    drive(0, 1'b1, simple(0, 30, 1'b1, 1'b1));
    drive(3, 1'b1, simple(3, 33, 1'b1, 1'b1));
    drive(1, 1'b1, simple(1, 20, 1'b1, 1'b0));
    #1;
    chk("lk_b0_ready", 256'(commit_ready), 256'(4'b0010));
    tick();
    chk("lk_b0_rd", 256'(wb_rd), 256'(20));
    chk("lk_b0_eop", 256'(wb_eop), 256'(0));
    drive(1, 1'b0, '0);
    #1;
    chk("lk_gap_ready", 256'(commit_ready), 256'(0));
    tick();
    chk("lk_gap_valid", 256'(wb_valid), 256'(0));
    drive(1, 1'b1, simple(1, 21, 1'b1, 1'b0));
    #1;
    chk("lk_b1_ready", 256'(commit_ready), 256'(4'b0010));
    tick();
    chk("lk_b1_rd", 256'(wb_rd), 256'(21));
    drive(1, 1'b1, simple(1, 22, 1'b1, 1'b1));
    #1;
    chk("lk_b2_ready", 256'(commit_ready), 256'(4'b0010));
    tick();
    chk("lk_b2_rd", 256'(wb_rd), 256'(22));
    chk("lk_b2_eop", 256'(wb_eop), 256'(1));
    drive(1, 1'b0, '0);
    #1;
    chk("lk_post_ready", 256'(commit_ready), 256'(4'b1000));
    tick();
    chk("lk_src3_rd", 256'(wb_rd), 256'(33));
    drive(3, 1'b0, '0);
    #1;
    chk("lk_src0_ready", 256'(commit_ready), 256'(4'b0001));
    tick();
    chk("lk_src0_rd", 256'(wb_rd), 256'(30));
    chk("lk_count", 256'(commit_count), 256'(14));
    idle_all();

    // Counter wrap.
    force dut.count_q = '1;
    #1;
    release dut.count_q;
    #1;
    chk("wrap_pre", 256'(commit_count), 256'(44'hFFF_FFFF_FFFF));
    drive(2, 1'b1, simple(2, 7, 1'b1, 1'b1));
    tick();
    idle_all();
    chk("wrap_count", 256'(commit_count), 256'(0));

    // Reset mid-packet: src2 holds the lock when reset hits.
    drive(2, 1'b1, simple(2, 40, 1'b1, 1'b0));
    tick();
    chk("mr_lock_rd", 256'(wb_rd), 256'(40));
    drive(0, 1'b1, simple(0, 50, 1'b1, 1'b1));
    drive(2, 1'b1, simple(2, 41, 1'b1, 1'b1));
    reset = 1'b0;
    #1;
    chk("mr_valid", 256'(wb_valid), 256'(0));
    chk("mr_rd", 256'(wb_rd), 256'(0));
    chk("mr_data", 256'(wb_data), 256'(0));
    chk("mr_count", 256'(commit_count), 256'(0));
    chk("mr_ready", 256'(commit_ready), 256'(0));
    tick();
    reset = 1'b1;
    #1;
    chk("mr_rel_ready", 256'(commit_ready), 256'(4'b0001));
    tick();
    chk("mr_src0_rd", 256'(wb_rd), 256'(50));
    drive(0, 1'b0, '0);
    #1;
    chk("mr_src2_ready", 256'(commit_ready), 256'(4'b0100));
    tick();
    idle_all();
    chk("mr_src2_rd", 256'(wb_rd), 256'(41));
    chk("mr_src2_valid", 256'(wb_valid), 256'(1));
    chk("mr_final_count", 256'(commit_count), 256'(2));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
